r2r_dac_sequencer: RTL and testbench
====================================

Name: r2r_dac_sequencer

Overview:
Sample-rate sequencer driving the 8-bit R2R ladder DAC code bus from a Tiny Tapeout tile.
- Sources: a small sample FIFO (stream mode), or an internal sawtooth or triangle generator.
- A programmable prescaler sets the update rate.
- Configured through a 4-register write port; the top level maps ui_in/uio_in onto its inputs and dac_code onto uo_out.

Parameters:
DEPTH, 8, sample FIFO entries (power of 2, >=2)
DIV_W, 16, prescaler divider width (DIV_LO/DIV_HI give 16 bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  tile enable; low freezes prescaler and generators
cfg_we  in  1  config register write strobe
cfg_addr  in  2  0=MODE, 1=DIV_LO, 2=DIV_HI, 3=STEP
cfg_data  in  8  config write data
wr_valid  in  1  sample push request
wr_data  in  8  sample value
wr_ready  out  1  FIFO not full
dac_code  out  8  registered R2R ladder code
sample_tick  out  1  one-cycle pulse when dac_code updates
underrun  out  1  sticky: stream tick found FIFO empty
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - dac_code=0x00, sample_tick=0, underrun=0, FIFO empty (fifo_level=0, wr_ready=1).
  - MODE=0 (IDLE), DIV=0, STEP=0x01, prescaler=0, FSM=IDLE.
- Config writes take effect the cycle after cfg_we.
  - MODE[1:0]: 0=IDLE, 1=STREAM, 2=SAW, 3=TRI.
  - Any MODE write (same value included): flushes FIFO, clears underrun, resets prescaler to 0, sets TRI direction to up. dac_code is held.
  - DIV_LO/DIV_HI write: resets prescaler to 0.
  - STEP=0 is legal; generators then hold.
- Prescaler:
  - Counts 0..DIV while ena=1; internal tick when count==DIV, then count returns to 0.
  - DIV=0 gives a tick every ena cycle. Tick period = DIV+1 cycles.
  - ena=0 holds the count and suppresses ticks.
- FSM states:
  - IDLE: ticks ignored, dac_code held.
  - STREAM: on tick, if FIFO non-empty, pop and load dac_code with the head. If empty, hold dac_code, set underrun, no sample_tick.
  - SAW: on tick, dac_code <= dac_code+STEP mod 256.
  - TRI_UP: on tick, dac_code <= min(dac_code+STEP,255); on reaching 255, go to TRI_DOWN.
  - TRI_DOWN: on tick, dac_code <= max(dac_code-STEP,0); on reaching 0, go to TRI_UP.
  - A MODE write of 3 enters TRI_UP.
- Latency and sample_tick:
  - dac_code changes on the edge ending the tick cycle.
  - sample_tick is registered, high for exactly the cycle dac_code shows the new value.
  - Asserted only in STREAM (successful pop), SAW and TRI; asserted even when the value is unchanged (STEP=0).
- FIFO:
  - Push when wr_valid&wr_ready; no push when full; data is never overwritten.
  - Push is accepted in all modes and while ena=0.
  - Push and pop in the same cycle with level>0: both happen, level unchanged.
  - Push while empty on a tick: the new entry is not visible to that tick, so underrun is set.
  - Read/write pointers wrap modulo DEPTH.
- A cfg_we MODE write in the same cycle as a tick: the MODE write wins, no update or pop occurs.
- A cfg_we MODE write in the same cycle as a push: flush wins, the push is dropped.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
1. Reset, MODE=2, DIV=3, STEP=0x10, ena=1 -> sample_tick every 4 cycles; dac_code 0x10,0x20,...,0xF0,0x00 (wrap).
2. MODE=3, DIV=0, STEP=0x60 -> dac_code 0x60,0xC0,0xFF,0x9F,0x3F,0x00,0x60, one per cycle.
3. MODE=1, DIV=1, push 0xA5,0x5A,0x3C -> dac_code 0xA5,0x5A,0x3C on alternate cycles; next tick sets underrun=1 and holds 0x3C with no sample_tick; a MODE write clears underrun.
4. MODE=1, ena=0, push 9 samples with DEPTH=8 -> wr_ready=0 after the 8th, 9th dropped, fifo_level=8; raise ena -> samples 1..8 played in order.
5. Mid-SAW, pull rst_n low between clk edges -> dac_code=0x00 and sample_tick=0 immediately; after release, MODE=0 and ticks are ignored.
6. ena toggled low for 5 cycles in SAW with DIV=2 -> prescaler frozen, tick spacing extended by exactly 5 cycles.

Source files
------------

// File: rtl/r2r_dac_sequencer.sv
// Sample-rate sequencer for an 8-bit R2R ladder DAC.
// The DAC code comes from a sample FIFO, a sawtooth generator or a triangle generator, paced by a prescaler.
module r2r_dac_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [7:0]               cfg_data,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic [7:0]               dac_code,
    output logic                     sample_tick,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_SAW,
        ST_TRI_UP,
        ST_TRI_DOWN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       dac_q, dac_d;
    logic             tick_q, tick_d;
    logic             underrun_q, underrun_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       div_lo_q, div_lo_d;
    logic [7:0]       div_hi_q, div_hi_d;
    logic [7:0]       step_q, step_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_ready_q, wr_ready_d;
    logic [7:0]       mem_q [DEPTH];

    logic             mode_wr_c;
    logic             div_wr_c;
    logic [DIV_W-1:0] div_c;
    logic             tick_c;
    logic             push_c;
    logic             pop_c;
    logic [8:0]       sum_c;
    logic [8:0]       diff_c;

    // A mode write overrides any tick or push landing in the same cycle.
    assign mode_wr_c = cfg_we && (cfg_addr == 2'd0);
    assign div_wr_c  = cfg_we && ((cfg_addr == 2'd1) || (cfg_addr == 2'd2));
    assign div_c     = DIV_W'({div_hi_q, div_lo_q});
    assign tick_c    = ena && (cnt_q == div_c);
    assign push_c    = wr_valid && wr_ready_q && !mode_wr_c;
    assign pop_c     = tick_c && !mode_wr_c && (state_q == ST_STREAM) && (level_q != LW'(0));
    assign sum_c     = {1'b0, dac_q} + {1'b0, step_q};
    assign diff_c    = {1'b0, dac_q} - {1'b0, step_q};

    // Next-state: config registers, prescaler, FIFO pointers and DAC FSM.
    always_comb begin
        state_d    = state_q;
        dac_d      = dac_q;
        tick_d     = 1'b0;
        underrun_d = underrun_q;
        cnt_d      = cnt_q;
        div_lo_d   = div_lo_q;
        div_hi_d   = div_hi_q;
        step_d     = step_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        level_d    = level_q;

        if (cfg_we) begin
            case (cfg_addr)
                2'd1:    div_lo_d = cfg_data;
                2'd2:    div_hi_d = cfg_data;
                2'd3:    step_d   = cfg_data;
                default: ;
            endcase
        end

        if (mode_wr_c || div_wr_c || tick_c) begin
            cnt_d = '0;
        end else if (ena) begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (mode_wr_c) begin
            case (cfg_data[1:0])
                2'd1:    state_d = ST_STREAM;
                2'd2:    state_d = ST_SAW;
                2'd3:    state_d = ST_TRI_UP;
                default: state_d = ST_IDLE;
            endcase
            underrun_d = 1'b0;
            rd_d       = '0;
            wr_d       = '0;
            level_d    = '0;
        end else begin
            if (push_c) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop_c) begin
                rd_d = rd_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                level_d = level_q + LW'(1);
            end else if (pop_c && !push_c) begin
                level_d = level_q - LW'(1);
            end

            if (tick_c) begin
                case (state_q)
                    ST_STREAM: begin
                        if (pop_c) begin
                            dac_d  = mem_q[rd_q];
                            tick_d = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                    ST_SAW: begin
                        dac_d  = sum_c[7:0];
                        tick_d = 1'b1;
                    end
                    ST_TRI_UP: begin
                        tick_d = 1'b1;
                        if (sum_c >= 9'd255) begin
                            dac_d   = 8'hFF;
                            state_d = ST_TRI_DOWN;
                        end else begin
                            dac_d = sum_c[7:0];
                        end
                    end
                    ST_TRI_DOWN: begin
                        tick_d = 1'b1;
                        if (diff_c[8] || (diff_c[7:0] == 8'h00)) begin
                            dac_d   = 8'h00;
                            state_d = ST_TRI_UP;
                        end else begin
                            dac_d = diff_c[7:0];
                        end
                    end
                    default: ;
                endcase
            end
        end

        wr_ready_d = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dac_q      <= 8'h00;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
            div_lo_q   <= 8'h00;
            div_hi_q   <= 8'h00;
            step_q     <= 8'h01;
            rd_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            dac_q      <= dac_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
            div_lo_q   <= div_lo_d;
            div_hi_q   <= div_hi_d;
            step_q     <= step_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Sample storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_q] <= wr_data;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign dac_code    = dac_q;
    assign sample_tick = tick_q;
    assign underrun    = underrun_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Directed self-checking bench for r2r_dac_sequencer: per-cycle vector tables plus multi-cycle sequences.
module tb_r2r_dac_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] dac_code;
    logic       sample_tick;
    logic       underrun;
    logic [3:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    r2r_dac_sequencer #(.DEPTH(8), .DIV_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .dac_code    (dac_code),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       pre_rst;
        bit       we;
        bit [1:0] addr;
        bit [7:0] data;
        bit       wv;
        bit [7:0] wd;
        bit [7:0] exp_dac;
        bit       exp_tick;
        bit       exp_und;
        bit [3:0] exp_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit we, bit [1:0] a, bit [7:0] d, bit wv, bit [7:0] wd,
                                bit [7:0] ed, bit et, bit eu, bit [3:0] el);
        vec_t v;
        v.pre_rst = r;  v.we = we; v.addr = a; v.data = d; v.wv = wv; v.wd = wd;
        v.exp_dac = ed; v.exp_tick = et; v.exp_und = eu; v.exp_lvl = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
        wr_valid = 1'b0; wr_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Cycles until sample_tick is seen; a timeout counts as a failed comparison.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 64);
        if (!sample_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no sample_tick within %0d cycles at %0t", n, $time);
        end
    endtask

    initial begin
        int n;
        int n2;
        bit seen;

        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
        wr_valid = 1'b0; wr_data = 8'h00;

        // Reset state
        reset_dut();
        chk("rst_dac", dac_code, 8'h00);
        chk("rst_tick", sample_tick, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_ready", wr_ready, 1'b1);

        // Triangle with saturation, then a mode write that beats a tick
        vecs.push_back(mk(1, 1, 2'd3, 8'h60, 0, 8'h00, 8'h00, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd0, 8'h03, 0, 8'h00, 8'h00, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h60, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'hC0, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h9F, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h3F, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h60, 1, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd0, 8'h00, 0, 8'h00, 8'h60, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h60, 0, 0, 4'd0));
        // Stream with DIV=1: push/pop overlap, underrun on a push-during-tick, flush beats push
        vecs.push_back(mk(1, 1, 2'd1, 8'h01, 0, 8'h00, 8'h00, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd0, 8'h01, 0, 8'h00, 8'h00, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 1, 8'hA5, 8'h00, 0, 0, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 1, 8'h5A, 8'hA5, 1, 0, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 1, 8'h3C, 8'hA5, 0, 0, 4'd2));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h5A, 1, 0, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h5A, 0, 0, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h3C, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h3C, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 1, 8'h77, 8'h3C, 0, 1, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h3C, 0, 1, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h77, 1, 1, 4'd0));
        vecs.push_back(mk(0, 1, 2'd0, 8'h01, 1, 8'h11, 8'h77, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h77, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h77, 0, 1, 4'd0));

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) reset_dut();
            cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_data = vecs[i].data;
            wr_valid = vecs[i].wv; wr_data = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d_dac", i), dac_code, vecs[i].exp_dac);
            chk($sformatf("vec%0d_tick", i), sample_tick, vecs[i].exp_tick);
            chk($sformatf("vec%0d_underrun", i), underrun, vecs[i].exp_und);
            chk($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_lvl);
        end
        cfg_we = 1'b0; wr_valid = 1'b0;

        // Sawtooth, DIV=3, STEP=0x10: tick every 4 cycles, wraps to 0
        reset_dut();
        cfg_write(2'd1, 8'h03);
        cfg_write(2'd3, 8'h10);
        cfg_write(2'd0, 8'h02);
        for (int k = 1; k <= 16; k++) begin
            wait_tick(n);
            chk($sformatf("saw_gap%0d", k), n, 4);
            chk($sformatf("saw_dac%0d", k), dac_code, (k * 16) & 8'hFF);
        end

        // Stream with ena=0: flush, fill past full, then play back
        reset_dut();
        ena = 1'b0;
        cfg_write(2'd0, 8'h01);
        push(8'hEE);
        push(8'hEE);
        chk("pre_flush_level", fifo_level, 4'd2);
        cfg_write(2'd0, 8'h01);
        chk("flush_level", fifo_level, 4'd0);
        for (int k = 1; k <= 9; k++) begin
            push(8'(k));
            chk($sformatf("fill_level%0d", k), fifo_level, (k > 8) ? 8 : k);
            chk($sformatf("fill_ready%0d", k), wr_ready, (k < 8) ? 1'b1 : 1'b0);
        end
        chk("frozen_dac", dac_code, 8'h00);
        ena = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_tick(n);
            chk($sformatf("play_gap%0d", k), n, 1);
            chk($sformatf("play_dac%0d", k), dac_code, k);
        end
        @(negedge clk);
        chk("drain_underrun", underrun, 1'b1);
        chk("drain_tick", sample_tick, 1'b0);
        chk("drain_dac", dac_code, 8'h08);
        chk("drain_ready", wr_ready, 1'b1);

        // Asynchronous reset mid-sawtooth
        reset_dut();
        cfg_write(2'd0, 8'h02);
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        chk("pre_rst_dac", dac_code, 8'h03);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dac", dac_code, 8'h00);
        chk("async_tick", sample_tick, 1'b0);
        chk("async_level", fifo_level, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (sample_tick || dac_code != 8'h00) seen = 1'b1;
        end
        chk("post_rst_idle", seen, 1'b0);
        cfg_write(2'd0, 8'h02);
        chk("default_step_dac", dac_code, 8'h00);
        wait_tick(n);
        chk("default_step_gap", n, 1);
        chk("default_step_val", dac_code, 8'h01);

        // ena low for 5 cycles stretches one tick interval by exactly 5
        reset_dut();
        cfg_write(2'd1, 8'h02);
        cfg_write(2'd0, 8'h02);
        wait_tick(n);
        chk("ena_gap1", n, 3);
        wait_tick(n);
        chk("ena_gap2", n, 3);
        chk("ena_dac2", dac_code, 8'h02);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        wait_tick(n2);
        chk("ena_gap_stretched", n2 + 5, 8);
        chk("ena_dac3", dac_code, 8'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
